// File: rtl/free_list.sv
// Circular free list of physical register tags for an N-wide rename stage.
// Grants up to N tags per cycle, reclaims Told tags at retire, and rolls back on mispredict.
module free_list #(
  parameter  int ARCH_COUNT = 32,
  parameter  int PHYS_REGS  = 64,
  parameter  int N          = 3,
  localparam int FL_SIZE    = PHYS_REGS - ARCH_COUNT,
  localparam int PRW        = $clog2(PHYS_REGS),
  localparam int PTRW       = $clog2(FL_SIZE),
  localparam int CW         = $clog2(FL_SIZE + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N-1:0]       alloc_req,
  output logic               alloc_ok,
  output logic [N*PRW-1:0]   alloc_pr,
  input  logic [N-1:0]       Retire_EN,
  input  logic [N*PRW-1:0]   Told_in,
  input  logic               BPRecoverEN,
  output logic [CW-1:0]      free_count,
  output logic               fl_error
);

  localparam logic [PTRW:0] FL_SIZE_P = (PTRW+1)'(FL_SIZE);
  localparam logic [CW:0]   FL_SIZE_C = (CW+1)'(FL_SIZE);

  logic [PRW-1:0]  fl_mem [FL_SIZE];
  logic [PTRW-1:0] head, tail, arch_head;
  logic [CW-1:0]   count;

  logic [CW-1:0]   nalloc, nfree, granted;
  logic [CW:0]     sum;
  logic            err;
  logic [PTRW-1:0] head_next, tail_next, arch_head_next;
  logic [CW-1:0]   count_next;
  logic [PTRW-1:0] widx [N];

  // Pointer increment with compare-and-subtract so FL_SIZE need not be a power of two.
  function automatic logic [PTRW-1:0] ptr_add(input logic [PTRW-1:0] p, input logic [PTRW:0] inc);
    logic [PTRW:0] s;
    s = {1'b0, p} + inc;
    if (s >= FL_SIZE_P) s = s - FL_SIZE_P;
    return s[PTRW-1:0];
  endfunction

  always_comb begin
    logic [PTRW:0] k;
    logic [PTRW:0] j;
    nalloc   = '0;
    nfree    = '0;
    alloc_pr = '0;
    k        = '0;
    j        = '0;
    for (int i = 0; i < N; i++) begin
      nalloc = nalloc + CW'(alloc_req[i]);
      nfree  = nfree + CW'(Retire_EN[i]);
    end
    // Walk lanes oldest (N-1) to youngest (0) so older lanes take earlier slots.
    for (int i = N-1; i >= 0; i--) begin
      widx[i] = ptr_add(tail, j);
      if (alloc_req[i]) begin
        alloc_pr[i*PRW +: PRW] = fl_mem[ptr_add(head, k)];
        k = k + 1'b1;
      end
      if (Retire_EN[i]) j = j + 1'b1;
    end

    alloc_ok = (count >= nalloc) && !BPRecoverEN;
    granted  = alloc_ok ? nalloc : '0;
    sum      = {1'b0, count} + {1'b0, nfree} - {1'b0, granted};
    err      = (sum > FL_SIZE_C);

    tail_next      = ptr_add(tail, (PTRW+1)'(nfree));
    arch_head_next = ptr_add(arch_head, (PTRW+1)'(nfree));
    if (BPRecoverEN) begin
      head_next  = arch_head_next;
      count_next = CW'(FL_SIZE);
    end else begin
      head_next  = ptr_add(head, (PTRW+1)'(granted));
      count_next = err ? CW'(FL_SIZE) : sum[CW-1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FL_SIZE; i++) fl_mem[i] <= PRW'(ARCH_COUNT + i);
      head      <= '0;
      tail      <= '0;
      arch_head <= '0;
      count     <= CW'(FL_SIZE);
      fl_error  <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++)
        if (Retire_EN[i]) fl_mem[widx[i]] <= Told_in[i*PRW +: PRW];
      head      <= head_next;
      tail      <= tail_next;
      arch_head <= arch_head_next;
      count     <= count_next;
      fl_error  <= fl_error | err;
    end
  end

  assign free_count = count;

endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Circular allocator of free physical registers for the N-wide rename stage.
- Each cycle it grants up to N new physical tags to the dispatch lanes. These tags become the map table's maptable_new_pr.
- At retire it reclaims the Told tags of committing instructions.
- On BPRecoverEN it rolls back all speculative allocations in one cycle, in step with the map table's copy from the architectural map.

Parameters:
- ARCH_COUNT, 32, number of architectural registers.
- PHYS_REGS, 64, number of physical registers.
- N, 3, superscalar width. Lane N-1 is oldest, lane 0 is youngest.
- FL_SIZE (local), PHYS_REGS-ARCH_COUNT, number of free list entries.
- PRW (local), clog2(PHYS_REGS), tag width.
- PTRW (local), clog2(FL_SIZE), pointer width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- alloc_req  in  N  lane needs a destination PR (rd != x0).
- alloc_ok  out  1  the whole bundle's requests can be met this cycle.
- alloc_pr  out  N*PRW  granted tag per lane.
- Retire_EN  in  N  lane retires and frees its Told.
- Told_in  in  N*PRW  tag freed per retiring lane.
- BPRecoverEN  in  1  mispredict recovery.
- free_count  out  clog2(FL_SIZE+1)  current number of free entries.
- fl_error  out  1  sticky overflow/underflow flag.

Behaviour:
State:
- fl_mem[FL_SIZE] of PRW-bit entries.
- Pointers: head (next to allocate), tail (next write slot), arch_head (head as seen at commit).
- count register.

Reset (asynchronous, while reset=1):
- fl_mem[i] = ARCH_COUNT+i.
- head = tail = arch_head = 0.
- count = FL_SIZE.
- fl_error = 0.
- Resulting outputs: alloc_ok = 1, free_count = FL_SIZE. Granted tags start at 32 on the oldest requesting lane. Lanes with no request output 0.

Allocation (combinational from registered state):
- nalloc = popcount(alloc_req).
- Requesting lanes are numbered in order from oldest to youngest. Requester k (k = 0 for the oldest) gets alloc_pr = fl_mem[(head+k) mod FL_SIZE].
- Non-requesting lanes output 0.
- alloc_ok = (count >= nalloc) && !BPRecoverEN. All-or-nothing: if alloc_ok=0, head does not move and the dispatch stage stalls the whole bundle.
- nalloc = 0 gives alloc_ok = 1 with no state change.
- Tags are consumed at the clock edge only when alloc_ok=1: head += nalloc, modulo FL_SIZE.

Free at retire:
- nfree = popcount(Retire_EN).
- Retiring lanes are written in order from oldest to youngest: fl_mem[(tail+j) mod FL_SIZE] = Told_in of the j-th retiring lane.
- tail += nfree and arch_head += nfree, modulo FL_SIZE.
- Any Retire_EN pattern is legal, including non-contiguous lanes.

Count update:
- count_next = count - (alloc_ok ? nalloc : 0) + nfree.
- Simultaneous allocation and free in the same cycle are both applied.
- A freed tag is not allocatable until the next cycle. There is no same-cycle bypass.

Recovery (BPRecoverEN=1):
- Retires in the same cycle are still applied (write, tail, arch_head).
- head_next = arch_head + nfree, modulo FL_SIZE.
- count_next = FL_SIZE.
- Allocation is suppressed that cycle.
- Recovery always takes effect one edge later, the same edge at which the map table restores.

Wrap-around:
- All pointers wrap modulo FL_SIZE. FL_SIZE that is not a power of two must be supported, using compare-and-subtract.

Error:
- fl_error sets and stays set if count+nfree-nalloc_granted > FL_SIZE (double free).
- It is cleared only by reset.
- State still updates, with count saturated at FL_SIZE.

Timing:
- All outputs are valid in the same cycle from registered state (zero latency).
- One-cycle update latency for head, tail and count.

Test Plan:
1. Reset, then alloc_req=3'b111 → alloc_ok=1, alloc_pr[2]=32, [1]=33, [0]=34. Next cycle free_count=29.
2. alloc_req=3'b101 right after reset → alloc_pr[2]=32, alloc_pr[1]=0, alloc_pr[0]=33. free_count next = 30.
3. Drain: allocate 3 per cycle for 10 cycles (count=2), then req=3'b111 → alloc_ok=0, head unchanged. req=3'b110 → ok, count=0. Then any request gives alloc_ok=0 while req=0 gives alloc_ok=1.
4. At count=0, Retire_EN=3'b011 with Told=5,7 plus alloc_req=3'b100 in the same cycle → alloc_ok=0 that cycle. Next cycle count=2 and alloc_pr[2]=5.
5. After allocating 6 tags and retiring 2 (Told=3,9), assert BPRecoverEN with Retire_EN=3'b100, Told=12 → alloc_ok=0 that cycle. Next cycle free_count=32, head=3, and the next allocation returns fl_mem[3] (=35).
6. Wrap check: cycle through 40 alloc/free pairs so that tail passes index 31 → entries at index 0.. are reused in order, no fl_error. Then assert Retire_EN=3'b111 at count=32 → fl_error=1 and stays set until reset.
